// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// State encodings are fixed because state_o exposes them directly.
package pipe_hazard_ctrl_pkg;

  localparam int HZ_STATE_WIDTH    = 2;
  localparam int HZ_REG_ADDR_WIDTH = 5;
  localparam int HZ_FLUSH_CNT_W    = 4;
  localparam int HZ_WAIT_CNT_W     = 8;

  typedef enum logic [HZ_STATE_WIDTH-1:0] {
    HZ_RUN      = 2'd0,
    HZ_MDU_WAIT = 2'd1,
    HZ_MEM_WAIT = 2'd2,
    HZ_FLUSH    = 2'd3
  } hz_state_e;

  function automatic logic hz_is_wait(input hz_state_e s);
    return (s == HZ_MDU_WAIT) || (s == HZ_MEM_WAIT);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: a load in EX whose destination register
// is read by the instruction currently in ID.
module hazard_load_use_detect
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = HZ_REG_ADDR_WIDTH
) (
  input  logic                      id_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
  input  logic                      id_rs1_used_i,
  input  logic                      id_rs2_used_i,
  input  logic                      ex_valid_i,
  input  logic                      ex_is_load_i,
  input  logic                      ex_wen_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_i,
  output logic                      load_use_o
);

  logic ex_load_writes;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign ex_load_writes = ex_valid_i & ex_is_load_i & ex_wen_i & (ex_rd_i != '0);
  assign rs1_hit        = id_rs1_used_i & (id_rs1_i == ex_rd_i);
  assign rs2_hit        = id_rs2_used_i & (id_rs2_i == ex_rd_i);
  assign load_use_o     = id_valid_i & ex_load_writes & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: one prioritised FSM
// (mem_wait > MDU > redirect > load_use) driving PC and pipeline-register controls.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = HZ_REG_ADDR_WIDTH,
  parameter int FLUSH_CYCLES   = 2,
  parameter int MAX_WAIT       = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
  input  logic                      id_rs1_used_i,
  input  logic                      id_rs2_used_i,
  input  logic                      ex_valid_i,
  input  logic                      ex_is_load_i,
  input  logic                      ex_wen_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_i,
  input  logic                      mdu_start_i,
  input  logic                      mdu_done_i,
  input  logic                      mem_req_i,
  input  logic                      mem_ready_i,
  input  logic                      redirect_i,
  output logic                      pc_hold_o,
  output logic                      if_id_stall_o,
  output logic                      if_id_flush_o,
  output logic                      id_ex_hold_o,
  output logic                      id_ex_bubble_o,
  output logic                      ex_mem_hold_o,
  output logic [HZ_STATE_WIDTH-1:0] state_o,
  output logic                      timeout_o,
  output logic [31:0]               stall_cnt_o
);

  localparam logic [HZ_FLUSH_CNT_W-1:0] FLUSH_INIT = HZ_FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [HZ_WAIT_CNT_W-1:0]  WAIT_MAX   = HZ_WAIT_CNT_W'(MAX_WAIT);

  hz_state_e                 state_q, state_d;
  hz_state_e                 saved_q, saved_d;
  logic [HZ_FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [HZ_WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0]               stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic mem_wait;
  logic mdu_busy;
  logic in_wait;
  logic pc_hold, if_id_stall, if_id_flush, id_ex_hold, id_ex_bubble, ex_mem_hold;

  hazard_load_use_detect #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_load_use (
    .id_valid_i   (id_valid_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .id_rs1_used_i(id_rs1_used_i),
    .id_rs2_used_i(id_rs2_used_i),
    .ex_valid_i   (ex_valid_i),
    .ex_is_load_i (ex_is_load_i),
    .ex_wen_i     (ex_wen_i),
    .ex_rd_i      (ex_rd_i),
    .load_use_o   (load_use)
  );

  assign mem_wait = mem_req_i & ~mem_ready_i;
  assign mdu_busy = mdu_start_i & ~mdu_done_i;
  assign in_wait  = hz_is_wait(state_q);

  always_comb begin
    state_d      = state_q;
    saved_d      = saved_q;
    flush_cnt_d  = flush_cnt_q;
    pc_hold      = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_hold   = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_hold  = 1'b0;

    case (state_q)
      HZ_RUN: begin
        if (mem_wait) begin
          {pc_hold, if_id_stall, id_ex_hold, ex_mem_hold} = 4'b1111;
          saved_d = HZ_RUN;
          state_d = HZ_MEM_WAIT;
        end else if (mdu_busy) begin
          {pc_hold, if_id_stall, id_ex_hold} = 3'b111;
          state_d = HZ_MDU_WAIT;
        end else if (redirect_i) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            flush_cnt_d = FLUSH_INIT;
            state_d     = HZ_FLUSH;
          end
        end else if (load_use) begin
          {pc_hold, if_id_stall, id_ex_bubble} = 3'b111;
        end
      end

      HZ_MDU_WAIT: begin
        if (mdu_done_i) begin
          // The MDU result is ready but MEM is stalled: fall into a full freeze.
          if (mem_wait) begin
            {pc_hold, if_id_stall, id_ex_hold, ex_mem_hold} = 4'b1111;
            saved_d = HZ_RUN;
            state_d = HZ_MEM_WAIT;
          end else begin
            state_d = HZ_RUN;
          end
        end else begin
          {pc_hold, if_id_stall, id_ex_hold} = 3'b111;
          ex_mem_hold = mem_wait;
        end
      end

      HZ_MEM_WAIT: begin
        if (mem_wait) begin
          {pc_hold, if_id_stall, id_ex_hold, ex_mem_hold} = 4'b1111;
        end else begin
          state_d = saved_q;
        end
      end

      HZ_FLUSH: begin
        // EX only carries squashed slots here, so MDU/redirect/load_use are not acted on.
        if (mem_wait) begin
          {pc_hold, if_id_stall, id_ex_hold, ex_mem_hold} = 4'b1111;
          saved_d = HZ_FLUSH;
          state_d = HZ_MEM_WAIT;
        end else begin
          id_ex_bubble = 1'b1;
          flush_cnt_d  = flush_cnt_q - 1'b1;
          if (flush_cnt_q <= HZ_FLUSH_CNT_W'(1)) begin
            flush_cnt_d = '0;
            state_d     = HZ_RUN;
          end
        end
      end

      default: state_d = HZ_RUN;
    endcase
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (hz_is_wait(state_d) && (state_d != state_q)) begin
      wait_cnt_d = '0;
    end else if (in_wait) begin
      if (wait_cnt_q != WAIT_MAX) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end else begin
      wait_cnt_d = '0;
    end
  end

  assign stall_cnt_d = stall_cnt_q + 32'(pc_hold_o);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HZ_RUN;
      saved_q     <= HZ_RUN;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Combinational outputs are gated so they read 0 during reset, not just after it.
  assign pc_hold_o      = rst_n & pc_hold;
  assign if_id_stall_o  = rst_n & if_id_stall;
  assign if_id_flush_o  = rst_n & if_id_flush;
  assign id_ex_hold_o   = rst_n & id_ex_hold;
  assign id_ex_bubble_o = rst_n & id_ex_bubble & ~id_ex_hold;
  assign ex_mem_hold_o  = rst_n & ex_mem_hold;
  assign state_o        = rst_n ? state_q : HZ_RUN;
  assign timeout_o      = rst_n & in_wait & (wait_cnt_q == WAIT_MAX);
  assign stall_cnt_o    = rst_n ? stall_cnt_q : '0;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl (FLUSH_CYCLES=2, MAX_WAIT=8).
module tb_pipe_hazard_ctrl;

  localparam int RAW = 5;
  localparam logic [5:0] NO = 6'b000000;
  localparam logic [5:0] H4 = 6'b110101; // pc, if_id_stall, id_ex_hold, ex_mem_hold
  localparam logic [5:0] H3 = 6'b110100; // pc, if_id_stall, id_ex_hold
  localparam logic [5:0] LU = 6'b110010; // pc, if_id_stall, id_ex_bubble
  localparam logic [5:0] RD = 6'b001010; // if_id_flush, id_ex_bubble
  localparam logic [5:0] BB = 6'b000010; // id_ex_bubble

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_rs1_used, id_rs2_used, ex_valid, ex_is_load, ex_wen;
  logic [RAW-1:0] id_rs1, id_rs2, ex_rd;
  logic mdu_start, mdu_done, mem_req, mem_ready, redirect;
  logic pc_hold, if_id_stall, if_id_flush, id_ex_hold, id_ex_bubble, ex_mem_hold;
  logic [1:0] state;
  logic timeout;
  logic [31:0] stall_cnt;
  logic [7:0] obs;
  logic [31:0] exp_stall;
  int n_vec = 0;
  int n_err = 0;

  pipe_hazard_ctrl #(
    .REG_ADDR_WIDTH(RAW),
    .FLUSH_CYCLES  (2),
    .MAX_WAIT      (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid_i    (id_valid),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_rs1_used_i (id_rs1_used),
    .id_rs2_used_i (id_rs2_used),
    .ex_valid_i    (ex_valid),
    .ex_is_load_i  (ex_is_load),
    .ex_wen_i      (ex_wen),
    .ex_rd_i       (ex_rd),
    .mdu_start_i   (mdu_start),
    .mdu_done_i    (mdu_done),
    .mem_req_i     (mem_req),
    .mem_ready_i   (mem_ready),
    .redirect_i    (redirect),
    .pc_hold_o     (pc_hold),
    .if_id_stall_o (if_id_stall),
    .if_id_flush_o (if_id_flush),
    .id_ex_hold_o  (id_ex_hold),
    .id_ex_bubble_o(id_ex_bubble),
    .ex_mem_hold_o (ex_mem_hold),
    .state_o       (state),
    .timeout_o     (timeout),
    .stall_cnt_o   (stall_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {state, pc_hold, if_id_stall, if_id_flush, id_ex_hold, id_ex_bubble, ex_mem_hold};

  task automatic clr();
    id_valid = 0; id_rs1_used = 0; id_rs2_used = 0;
    ex_valid = 0; ex_is_load = 0; ex_wen = 0;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    mdu_start = 0; mdu_done = 0; mem_req = 0; mem_ready = 0; redirect = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clr();
    mem_req = 1; redirect = 1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (obs !== {2'd0, NO}) begin n_err++; $display("FAIL reset_outs: got %b want %b", obs, {2'd0, NO}); end
    n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    n_vec++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    clr();
    rst_n = 1;
    #1;
    n_vec++; if (obs !== {2'd0, NO}) begin n_err++; $display("FAIL reset_release: got %b want %b", obs, {2'd0, NO}); end
    exp_stall = 0;
    tick();
  endtask

  task automatic test_load_use();
    clr();
    ex_valid = 1; ex_is_load = 1; ex_wen = 1; ex_rd = 5'd5;
    id_valid = 1; id_rs1 = 5'd5; id_rs1_used = 1; id_rs2 = 5'd3; id_rs2_used = 1;
    #1;
    n_vec++; if (obs !== {2'd0, LU}) begin n_err++; $display("FAIL lu_rs1_stall: got %b want %b", obs, {2'd0, LU}); end
    exp_stall++;
    tick();
    ex_valid = 0;
    #1;
    n_vec++; if (obs !== {2'd0, NO}) begin n_err++; $display("FAIL lu_release: got %b want %b", obs, {2'd0, NO}); end
    n_vec++; if (stall_cnt !== exp_stall) begin n_err++; $display("FAIL lu_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
    ex_valid = 1; ex_rd = 5'd0; id_rs1 = 5'd0;
    #1;
    n_vec++; if (obs !== {2'd0, NO}) begin n_err++; $display("FAIL lu_x0: got %b want %b", obs, {2'd0, NO}); end
    ex_rd = 5'd7; id_rs1 = 5'd5; id_rs2 = 5'd7;
    #1;
    n_vec++; if (obs !== {2'd0, LU}) begin n_err++; $display("FAIL lu_rs2_stall: got %b want %b", obs, {2'd0, LU}); end
    exp_stall++;
    tick();
    id_rs2_used = 0;
    #1;
    n_vec++; if (obs !== {2'd0, NO}) begin n_err++; $display("FAIL lu_rs2_unused: got %b want %b", obs, {2'd0, NO}); end
    id_rs2_used = 1; ex_is_load = 0;
    #1;
    n_vec++; if (obs !== {2'd0, NO}) begin n_err++; $display("FAIL lu_not_load: got %b want %b", obs, {2'd0, NO}); end
    clr();
    tick();
    n_vec++; if (stall_cnt !== exp_stall) begin n_err++; $display("FAIL lu_stall_cnt2: got %0d want %0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_mdu();
    clr();
    mdu_start = 1;
    #1;
    n_vec++; if (obs !== {2'd0, H3}) begin n_err++; $display("FAIL mdu_start: got %b want %b", obs, {2'd0, H3}); end
    exp_stall++;
    tick();
    mdu_start = 0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      n_vec++; if (obs !== {2'd1, H3}) begin n_err++; $display("FAIL mdu_wait_%0d: got %b want %b", k, obs, {2'd1, H3}); end
      exp_stall++;
      tick();
    end
    mdu_done = 1;
    #1;
    n_vec++; if (obs !== {2'd1, NO}) begin n_err++; $display("FAIL mdu_done: got %b want %b", obs, {2'd1, NO}); end
    tick();
    mdu_done = 0;
    #1;
    n_vec++; if (obs !== {2'd0, NO}) begin n_err++; $display("FAIL mdu_run: got %b want %b", obs, {2'd0, NO}); end
    n_vec++; if (stall_cnt !== exp_stall) begin n_err++; $display("FAIL mdu_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_redirect();
    clr();
    redirect = 1;
    #1;
    n_vec++; if (obs !== {2'd0, RD}) begin n_err++; $display("FAIL redir_c0: got %b want %b", obs, {2'd0, RD}); end
    tick();
    redirect = 0;
    #1;
    n_vec++; if (obs !== {2'd3, BB}) begin n_err++; $display("FAIL redir_c1: got %b want %b", obs, {2'd3, BB}); end
    tick();
    n_vec++; if (obs !== {2'd0, NO}) begin n_err++; $display("FAIL redir_c2: got %b want %b", obs, {2'd0, NO}); end
  endtask

  task automatic test_collision();
    clr();
    mem_req = 1; redirect = 1;
    ex_valid = 1; ex_is_load = 1; ex_wen = 1; ex_rd = 5'd9;
    id_valid = 1; id_rs1 = 5'd9; id_rs1_used = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++;
      if (obs !== {(k == 0) ? 2'd0 : 2'd2, H4}) begin
        n_err++; $display("FAIL coll_hold_%0d: got %b want %b", k, obs, {(k == 0) ? 2'd0 : 2'd2, H4});
      end
      exp_stall++;
      tick();
    end
    mem_ready = 1;
    #1;
    n_vec++; if (obs !== {2'd2, NO}) begin n_err++; $display("FAIL coll_release: got %b want %b", obs, {2'd2, NO}); end
    tick();
    clr();
    redirect = 1;
    #1;
    n_vec++; if (obs !== {2'd0, RD}) begin n_err++; $display("FAIL coll_redir: got %b want %b", obs, {2'd0, RD}); end
    tick();
    redirect = 0;
    #1;
    n_vec++; if (obs !== {2'd3, BB}) begin n_err++; $display("FAIL coll_flush: got %b want %b", obs, {2'd3, BB}); end
    tick();
    n_vec++; if (stall_cnt !== exp_stall) begin n_err++; $display("FAIL coll_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_flush_mem();
    clr();
    redirect = 1;
    #1;
    tick();
    redirect = 0; mem_req = 1;
    #1;
    n_vec++; if (obs !== {2'd3, H4}) begin n_err++; $display("FAIL fm_hold_wins: got %b want %b", obs, {2'd3, H4}); end
    exp_stall++;
    tick();
    n_vec++; if (obs !== {2'd2, H4}) begin n_err++; $display("FAIL fm_memwait: got %b want %b", obs, {2'd2, H4}); end
    exp_stall++;
    tick();
    mem_ready = 1;
    #1;
    tick();
    clr();
    #1;
    n_vec++; if (obs !== {2'd3, BB}) begin n_err++; $display("FAIL fm_resume: got %b want %b", obs, {2'd3, BB}); end
    tick();
    n_vec++; if (obs !== {2'd0, NO}) begin n_err++; $display("FAIL fm_done: got %b want %b", obs, {2'd0, NO}); end
  endtask

  task automatic test_watchdog();
    clr();
    mem_req = 1;
    #1;
    n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL wd_entry: got %b want 0", timeout); end
    exp_stall++;
    tick();
    for (int k = 1; k <= 11; k++) begin
      n_vec++;
      if (obs !== {2'd2, H4} || timeout !== (k >= 9)) begin
        n_err++; $display("FAIL wd_cycle_%0d: got %b/%b want %b/%b", k, obs, timeout, {2'd2, H4}, (k >= 9));
      end
      exp_stall++;
      tick();
    end
    mem_ready = 1;
    #1;
    n_vec++; if (obs !== {2'd2, NO}) begin n_err++; $display("FAIL wd_release: got %b want %b", obs, {2'd2, NO}); end
    tick();
    clr();
    #1;
    n_vec++; if (obs !== {2'd0, NO} || timeout !== 1'b0) begin n_err++; $display("FAIL wd_cleared: got %b/%b want %b/0", obs, timeout, {2'd0, NO}); end
    n_vec++; if (stall_cnt !== exp_stall) begin n_err++; $display("FAIL wd_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_reset_mid();
    clr();
    mdu_start = 1;
    #1;
    tick();
    mdu_start = 0;
    tick();
    redirect = 1; mem_req = 1;
    #1;
    n_vec++; if (obs !== {2'd1, H4}) begin n_err++; $display("FAIL rm_pre: got %b want %b", obs, {2'd1, H4}); end
    rst_n = 0;
    #1;
    n_vec++; if (obs !== {2'd0, NO} || timeout !== 1'b0 || stall_cnt !== 32'd0) begin
      n_err++; $display("FAIL rm_async: got %b/%b/%0d want %b/0/0", obs, timeout, stall_cnt, {2'd0, NO});
    end
    tick();
    clr();
    rst_n = 1;
    exp_stall = 0;
    #1;
    n_vec++; if (obs !== {2'd0, NO}) begin n_err++; $display("FAIL rm_release: got %b want %b", obs, {2'd0, NO}); end
    redirect = 1;
    #1;
    n_vec++; if (obs !== {2'd0, RD}) begin n_err++; $display("FAIL rm_run: got %b want %b", obs, {2'd0, RD}); end
    tick();
    redirect = 0;
    #1;
    n_vec++; if (obs !== {2'd3, BB}) begin n_err++; $display("FAIL rm_flush_cnt: got %b want %b", obs, {2'd3, BB}); end
    tick();
    n_vec++; if (obs !== {2'd0, NO} || stall_cnt !== exp_stall) begin
      n_err++; $display("FAIL rm_final: got %b/%0d want %b/%0d", obs, stall_cnt, {2'd0, NO}, exp_stall);
    end
  endtask

  initial begin
    exp_stall = 0;
    test_reset();
    test_load_use();
    test_mdu();
    test_redirect();
    test_collision();
    test_flush_mem();
    test_watchdog();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "simulation time limit");
  end

endmodule
